// File: rtl/det_log_pkg.sv
// Shared constants, types and helpers for the detector event logger.
package det_log_pkg;

  localparam int unsigned DET_TS_W  = 16;
  localparam int unsigned DET_DEPTH = 8;
  localparam int unsigned DET_CNT_W = 16;

  typedef logic [DET_TS_W-1:0] det_ts_t;

  // Level counter must represent 0..depth inclusive.
  function automatic int unsigned det_lvl_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/det_sync_fifo.sv
// Same-clock show-ahead FIFO with separate level counter and synchronous flush.
module det_sync_fifo
  import det_log_pkg::*;
#(
  parameter int unsigned DW    = DET_TS_W,
  parameter int unsigned DEPTH = DET_DEPTH
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_push,
  input  logic [DW-1:0]               i_data,
  input  logic                        i_pop,
  input  logic                        i_flush,
  output logic                        o_full,
  output logic                        o_empty,
  output logic [det_lvl_w(DEPTH)-1:0] o_level,
  output logic [DW-1:0]               o_head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = det_lvl_w(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          w_pop_ok;
  logic          w_push_ok;

  assign o_full  = (r_level == LW'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;

  // Flush wins; a pop frees a slot so a push into a full FIFO still lands.
  assign w_pop_ok  = i_pop && !o_empty && !i_flush;
  assign w_push_ok = i_push && !i_flush && (!o_full || w_pop_ok);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
  end

  // Head reads as zero when empty so the output has a defined reset value.
  assign o_head = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/detect_event_logger.sv
// Time-stamps detector pulses into a FIFO, with saturating event count and sticky overflow.
module detect_event_logger
  import det_log_pkg::*;
#(
  parameter int unsigned TS_W  = DET_TS_W,
  parameter int unsigned DEPTH = DET_DEPTH,
  parameter int unsigned CNT_W = DET_CNT_W
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_detected,
  input  logic                        i_pop,
  input  logic                        i_clear,
  output logic                        o_evt_valid,
  output logic [TS_W-1:0]             o_evt_ts,
  output logic [CNT_W-1:0]            o_evt_count,
  output logic [det_lvl_w(DEPTH)-1:0] o_fifo_level,
  output logic                        o_overflow
);

  logic [TS_W-1:0]  r_ts_ctr;
  logic [CNT_W-1:0] r_evt_count;
  logic             r_overflow;
  logic             w_full;
  logic             w_empty;
  logic             w_drop;

  det_sync_fifo #(
    .DW    (TS_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (i_detected),
    .i_data  (r_ts_ctr),
    .i_pop   (i_pop),
    .i_flush (i_clear),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (o_fifo_level),
    .o_head  (o_evt_ts)
  );

  // A full FIFO always has a valid head, so any pop makes room for the push.
  assign w_drop = i_detected && !i_clear && w_full && !i_pop;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_ts_ctr    <= '0;
      r_evt_count <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_ts_ctr <= r_ts_ctr + TS_W'(1);
      if (i_clear) begin
        r_evt_count <= '0;
        r_overflow  <= 1'b0;
      end else begin
        if (i_detected && (r_evt_count != '1)) r_evt_count <= r_evt_count + CNT_W'(1);
        if (w_drop) r_overflow <= 1'b1;
      end
    end
  end

  assign o_evt_valid = !w_empty;
  assign o_evt_count = r_evt_count;
  assign o_overflow  = r_overflow;

endmodule
